// File: rtl/uart_tx_frame_pkg.sv
// Shared UART TX definitions: FSM state encoding, supported prescale values, parity types.
package uart_tx_frame_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_t;

    localparam logic [4:0] PRESCALE_4 = 5'd4;
    localparam logic [4:0] PRESCALE_8 = 5'd8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic prescale_ok(input logic [4:0] p);
        return (p == PRESCALE_4) || (p == PRESCALE_8);
    endfunction

    function automatic logic parity_bit(input logic [7:0] d, input logic typ);
        logic r;
        case (typ)
            PAR_EVEN: r = ^d;
            PAR_ODD:  r = ~^d;
            default:  r = ^d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Per-bit timing for the UART transmitter: counts P clocks per bit and steps the data bit index.
module uart_tx_bit_timer
    import uart_tx_frame_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       clear,
    input  logic       data_phase,
    input  logic [4:0] prescale,
    output logic       bit_done,
    output logic [2:0] bit_idx
);

    logic [2:0] edge_cnt;

    // prescale is the value latched at acceptance, so a live port change cannot stretch a bit
    assign bit_done = ({2'b00, edge_cnt} == (prescale - 5'd1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_idx  <= '0;
        end else if (clear) begin
            edge_cnt <= '0;
            bit_idx  <= '0;
        end else if (bit_done) begin
            edge_cnt <= '0;
            if (data_phase) bit_idx <= bit_idx + 3'd1;
        end else begin
            edge_cnt <= edge_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, one stop bit; P clocks per bit.
module uart_tx_frame
    import uart_tx_frame_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [4:0]            prescale,
    output logic                  TX_OUT,
    output logic                  Busy
);

    tx_state_t             state, state_nxt;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  par_en_reg;
    logic                  par_bit_reg;
    logic [4:0]            p_reg;
    logic                  tx_reg, tx_nxt;
    logic                  busy_reg, busy_nxt;
    logic                  load;
    logic                  bit_done;
    logic [2:0]            bit_idx;

    uart_tx_bit_timer u_timer (
        .CLK        (CLK),
        .RST        (RST),
        .clear      (state == S_IDLE),
        .data_phase (state == S_DATA),
        .prescale   (p_reg),
        .bit_done   (bit_done),
        .bit_idx    (bit_idx)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= S_IDLE;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
            data_reg    <= '0;
            par_en_reg  <= 1'b0;
            par_bit_reg <= 1'b0;
            p_reg       <= '0;
        end else begin
            state    <= state_nxt;
            tx_reg   <= tx_nxt;
            busy_reg <= busy_nxt;
            if (load) begin
                data_reg    <= P_DATA;
                par_en_reg  <= PAR_EN;
                par_bit_reg <= parity_bit(P_DATA, PAR_TYP);
                p_reg       <= prescale;
            end
        end
    end

    // TX_OUT is registered, so the line value for the upcoming bit is chosen on the transition edge
    always_comb begin
        state_nxt = state;
        tx_nxt    = tx_reg;
        busy_nxt  = busy_reg;
        load      = 1'b0;
        case (state)
            S_IDLE: begin
                tx_nxt = 1'b1;
                if (Data_Valid && prescale_ok(prescale)) begin
                    load      = 1'b1;
                    state_nxt = S_START;
                    tx_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_nxt = S_DATA;
                    tx_nxt    = data_reg[0];
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    if (bit_idx == 3'd7) begin
                        if (par_en_reg) begin
                            state_nxt = S_PARITY;
                            tx_nxt    = par_bit_reg;
                        end else begin
                            state_nxt = S_STOP;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        tx_nxt = data_reg[bit_idx + 3'd1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_done) begin
                    state_nxt = S_STOP;
                    tx_nxt    = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    state_nxt = S_IDLE;
                    tx_nxt    = 1'b1;
                    busy_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    assign TX_OUT = tx_reg;
    assign Busy   = busy_reg;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed self-checking bench for uart_tx_frame: waveform per clock, parity, back-to-back, reset abort.
module tb_uart_tx_frame;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = '0;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [4:0] prescale = 5'd8;
    logic       TX_OUT;
    logic       Busy;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .prescale   (prescale),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    // Expected line value at clock i of a frame (i=0 is the first clock after acceptance)
    function automatic logic exp_bit(input logic [7:0] d, input int p, input logic pe,
                                     input logic pb, input int i);
        int b;
        b = i / p;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (pe && b == 9) return pb;
        return 1'b1;
    endfunction

    // Drive one request; returns at the falling edge right after the accepting rising edge
    task automatic start_frame(input logic [7:0] d, input logic [4:0] p, input logic pe, input logic pt);
        @(negedge CLK);
        P_DATA = d; prescale = p; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0; Data_Valid = 1'b1; P_DATA = 8'hA5; prescale = 5'd8;
        repeat (3) @(negedge CLK);
        checks++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold tx=%b busy=%b expected tx=1 busy=0", TX_OUT, Busy);
        end
        RST = 1'b1; Data_Valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            checks++;
            if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle clk %0d tx=%b busy=%b expected tx=1 busy=0", i, TX_OUT, Busy);
            end
        end
    endtask

    task automatic test_p8_nopar();
        logic e;
        start_frame(8'hA5, 5'd8, 1'b0, 1'b0);
        for (int i = 0; i < 80; i++) begin
            if (i > 0) @(negedge CLK);
            e = exp_bit(8'hA5, 8, 1'b0, 1'b0, i);
            checks++;
            if (TX_OUT !== e || Busy !== 1'b1) begin
                errors++;
                $display("FAIL p8_frame clk %0d tx=%b busy=%b expected tx=%b busy=1", i, TX_OUT, Busy, e);
            end
        end
        @(negedge CLK);
        checks++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL p8_end tx=%b busy=%b expected tx=1 busy=0", TX_OUT, Busy);
        end
    endtask

    task automatic test_p4_parity();
        logic e;
        logic pb;
        for (int t = 0; t < 2; t++) begin
            pb = (t == 1);  // 8'hA5 has four ones: even parity 0, odd parity 1
            start_frame(8'hA5, 5'd4, 1'b1, pb);
            for (int i = 0; i < 44; i++) begin
                if (i > 0) @(negedge CLK);
                e = exp_bit(8'hA5, 4, 1'b1, pb, i);
                checks++;
                if (TX_OUT !== e || Busy !== 1'b1) begin
                    errors++;
                    $display("FAIL p4_parity typ %0d clk %0d tx=%b busy=%b expected tx=%b busy=1",
                             t, i, TX_OUT, Busy, e);
                end
            end
            @(negedge CLK);
            checks++;
            if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
                errors++;
                $display("FAIL p4_parity_end typ %0d tx=%b busy=%b expected tx=1 busy=0", t, TX_OUT, Busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic et, eb;
        @(negedge CLK);
        P_DATA = 8'h5A; prescale = 5'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        for (int i = 0; i <= 125; i++) begin
            @(negedge CLK);
            if (i == 4) begin
                P_DATA = 8'h3C; prescale = 5'd4; PAR_EN = 1'b1; PAR_TYP = 1'b1;
            end
            if (i == 81) Data_Valid = 1'b0;
            if (i < 80) begin
                et = exp_bit(8'h5A, 8, 1'b0, 1'b0, i); eb = 1'b1;
            end else if (i == 80) begin
                et = 1'b1; eb = 1'b0;
            end else if (i < 125) begin
                et = exp_bit(8'h3C, 4, 1'b1, 1'b1, i - 81); eb = 1'b1;
            end else begin
                et = 1'b1; eb = 1'b0;
            end
            checks++;
            if (TX_OUT !== et || Busy !== eb) begin
                errors++;
                $display("FAIL back_to_back clk %0d tx=%b busy=%b expected tx=%b busy=%b",
                         i, TX_OUT, Busy, et, eb);
            end
        end
    endtask

    task automatic test_bad_prescale();
        @(negedge CLK);
        prescale = 5'd16; P_DATA = 8'hFF; Data_Valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            checks++;
            if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
                errors++;
                $display("FAIL bad_prescale clk %0d tx=%b busy=%b expected tx=1 busy=0", i, TX_OUT, Busy);
            end
        end
        Data_Valid = 1'b0; prescale = 5'd8;
    endtask

    task automatic test_reset_midframe();
        logic e;
        start_frame(8'hA5, 5'd8, 1'b0, 1'b0);
        for (int i = 0; i <= 35; i++) begin
            if (i > 0) @(negedge CLK);
            e = exp_bit(8'hA5, 8, 1'b0, 1'b0, i);
            checks++;
            if (TX_OUT !== e || Busy !== 1'b1) begin
                errors++;
                $display("FAIL pre_abort clk %0d tx=%b busy=%b expected tx=%b busy=1", i, TX_OUT, Busy, e);
            end
        end
        RST = 1'b0;
        #1;
        checks++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_async tx=%b busy=%b expected tx=1 busy=0", TX_OUT, Busy);
        end
        @(negedge CLK);
        RST = 1'b1;
        start_frame(8'h3C, 5'd8, 1'b0, 1'b0);
        for (int i = 0; i <= 80; i++) begin
            if (i > 0) @(negedge CLK);
            e = (i < 80) ? exp_bit(8'h3C, 8, 1'b0, 1'b0, i) : 1'b1;
            checks++;
            if (TX_OUT !== e || Busy !== (i < 80)) begin
                errors++;
                $display("FAIL post_abort clk %0d tx=%b busy=%b expected tx=%b busy=%b",
                         i, TX_OUT, Busy, e, (i < 80));
            end
        end
    endtask

    task automatic test_loopback();
        logic [7:0] bytes [6];
        logic [9:0] f;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55;
        bytes[3] = 8'hAA; bytes[4] = 8'h80; bytes[5] = 8'h01;
        for (int n = 0; n < 6; n++) begin
            f = '0;
            start_frame(bytes[n], 5'd8, 1'b0, 1'b0);
            for (int i = 0; i < 80; i++) begin
                if (i > 0) @(negedge CLK);
                if (i % 8 == 4) f[i / 8] = TX_OUT;  // mid-bit sample, as a receiver would
            end
            @(negedge CLK);
            checks++;
            if (f[0] !== 1'b0 || f[9] !== 1'b1 || f[8:1] !== bytes[n]) begin
                errors++;
                $display("FAIL loopback byte %0d got data=%h start=%b stop=%b expected data=%h start=0 stop=1",
                         n, f[8:1], f[0], f[9], bytes[n]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_p8_nopar();
        test_p4_parity();
        test_back_to_back();
        test_bad_prescale();
        test_reset_midframe();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
